// File: rtl/vga_sync.sv
// VGA 640x480@60 timing generator: pixel-rate tick enable from the system clock,
// pixel/line counters, registered active-low syncs and frame boundary pulse.
module vga_sync #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;

    logic tick;
    logic x_wrap;
    logic y_wrap;

    assign tick   = (div_q == DIV_LAST);
    assign x_wrap = (x_q == X_LAST);
    assign y_wrap = (y_q == Y_LAST);

    always_comb begin
        div_d   = tick ? '0 : div_q + DIV_ONE;
        x_d     = x_q;
        y_d     = y_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        if (tick) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            end
            // Syncs are decoded from the coordinates being loaded so they line up with x/y.
            hsync_d = !((x_d >= HS_START) && (x_d <= HS_END));
            vsync_d = !((y_d >= VS_START) && (y_d <= VS_END));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign p_tick     = tick;
    assign x          = x_q;
    assign y          = y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign video_on   = (x_q < X_VIS) && (y_q < Y_VIS);
    assign frame_tick = tick && x_wrap && y_wrap;

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync: default timing, CLK_DIV=2 default timing, and a
// reduced-geometry instance to cover frame wrap, vsync and mid-frame reset quickly.
module tb_vga_sync;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_s;

    logic       pt_a, vo_a, hs_a, vs_a, ft_a;
    logic [9:0] x_a, y_a;
    logic       pt_b, vo_b, hs_b, vs_b, ft_b;
    logic [9:0] x_b, y_b;
    logic       pt_s, vo_s, hs_s, vs_s, ft_s;
    logic [9:0] x_s, y_s;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_sync dut_a (
        .clk(clk), .reset(reset_a), .p_tick(pt_a), .x(x_a), .y(y_a),
        .video_on(vo_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
    );

    vga_sync #(.CLK_DIV(2)) dut_b (
        .clk(clk), .reset(reset_a), .p_tick(pt_b), .x(x_b), .y(y_b),
        .video_on(vo_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
    );

    // Small geometry: H_TOTAL=15 (hsync low x 10..12), V_TOTAL=10 (vsync low y 7..8).
    vga_sync #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(3), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .clk(clk), .reset(reset_s), .p_tick(pt_s), .x(x_s), .y(y_s),
        .video_on(vo_s), .hsync(hs_s), .vsync(vs_s), .frame_tick(ft_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n, ex, ey;
        int hs_low, ticks, hs_fall_x, vo_fall_x, y1_x;
        logic hs_prev, vo_prev;
        int vs_low, refresh_cnt, refresh_vo, ft_cnt, ft_first, ft_second;

        hs_low = 0; ticks = 0; hs_fall_x = -1; vo_fall_x = -1; y1_x = -1;
        hs_prev = 1'b1; vo_prev = 1'b1;
        vs_low = 0; refresh_cnt = 0; refresh_vo = 0; ft_cnt = 0; ft_first = -1; ft_second = -1;

        reset_a = 1'b1;
        reset_s = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_hsync", hs_a, 1);
        chk("rst_vsync", vs_a, 1);
        chk("rst_ptick", pt_a, 0);
        chk("rst_frame_tick", ft_a, 0);
        chk("rst_video_on", vo_a, 1);
        chk("rst_s_x", x_s, 0);

        // Default geometry: run just under two lines and stop at x=700, y=1.
        reset_a = 1'b0;
        for (int k = 0; k <= 6000; k++) begin
            @(negedge clk);
            n  = (k + 1) / 4;
            ex = n % 800;
            ey = n / 800;
            chk($sformatf("a_ptick@%0d", k), pt_a, (k % 4 == 2));
            chk($sformatf("a_x@%0d", k), x_a, ex);
            chk($sformatf("a_y@%0d", k), y_a, ey);
            chk($sformatf("a_hsync@%0d", k), hs_a, !(ex >= 656 && ex <= 751));
            chk($sformatf("a_vsync@%0d", k), vs_a, 1);
            chk($sformatf("a_video@%0d", k), vo_a, (ex < 640 && ey < 480));
            chk($sformatf("a_ftick@%0d", k), ft_a, 0);

            n  = (k + 1) / 2;
            ex = n % 800;
            ey = n / 800;
            chk($sformatf("b_ptick@%0d", k), pt_b, (k % 2 == 0));
            chk($sformatf("b_x@%0d", k), x_b, ex);
            chk($sformatf("b_y@%0d", k), y_b, ey);
            chk($sformatf("b_hsync@%0d", k), hs_b, !(ex >= 656 && ex <= 751));

            if (k < 3200) begin
                if (!hs_a) hs_low++;
                if (pt_a) ticks++;
                if (hs_prev && !hs_a && hs_fall_x < 0) hs_fall_x = x_a;
                if (vo_prev && !vo_a && vo_fall_x < 0) vo_fall_x = x_a;
            end
            if (y_a == 10'd1 && y1_x < 0) y1_x = x_a;
            hs_prev = hs_a;
            vo_prev = vo_a;
        end

        chk("line_ptick_count", ticks, 800);
        chk("line_hsync_low_clks", hs_low, 384);
        chk("hsync_fall_x", hs_fall_x, 656);
        chk("video_fall_x", vo_fall_x, 640);
        chk("y_inc_at_x", y1_x, 0);
        chk("pre_rst_x", x_a, 700);
        chk("pre_rst_hsync", hs_a, 0);

        // Asynchronous reset mid-line: outputs return within the same clock.
        reset_a = 1'b1;
        #1;
        chk("mid_rst_x", x_a, 0);
        chk("mid_rst_y", y_a, 0);
        chk("mid_rst_hsync", hs_a, 1);
        chk("mid_rst_ptick", pt_a, 0);
        chk("mid_rst_b_x", x_b, 0);
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("resume_a_ptick@%0d", k), pt_a, (k % 4 == 2));
            chk($sformatf("resume_a_x@%0d", k), x_a, (k + 1) / 4);
            chk($sformatf("resume_b_ptick@%0d", k), pt_b, (k % 2 == 0));
        end

        // Reduced geometry: two full frames, stop at x=11, y=8 (both syncs low).
        reset_s = 1'b0;
        for (int k = 0; k <= 861; k++) begin
            @(negedge clk);
            n  = (k + 1) / 2;
            ex = n % 15;
            ey = (n / 15) % 10;
            chk($sformatf("s_ptick@%0d", k), pt_s, (k % 2 == 0));
            chk($sformatf("s_x@%0d", k), x_s, ex);
            chk($sformatf("s_y@%0d", k), y_s, ey);
            chk($sformatf("s_hsync@%0d", k), hs_s, !(ex >= 10 && ex <= 12));
            chk($sformatf("s_vsync@%0d", k), vs_s, !(ey >= 7 && ey <= 8));
            chk($sformatf("s_video@%0d", k), vo_s, (ex < 8 && ey < 4));
            chk($sformatf("s_ftick@%0d", k), ft_s, ((k % 2 == 0) && ex == 14 && ey == 9));
            if (ft_s) begin
                if (ft_first < 0) ft_first = k;
                else if (ft_second < 0) ft_second = k;
            end
            if (k < 300) begin
                if (!vs_s) vs_low++;
                if (ft_s) ft_cnt++;
                if (y_s == 10'd5 && x_s == 10'd0) begin
                    refresh_cnt++;
                    if (vo_s) refresh_vo++;
                end
            end
        end

        chk("s_vsync_low_clks", vs_low, 60);
        chk("s_ftick_per_frame", ft_cnt, 1);
        chk("s_ftick_first", ft_first, 298);
        chk("s_frame_period", ft_second - ft_first, 300);
        chk("s_refresh_clks", refresh_cnt, 2);
        chk("s_refresh_video", refresh_vo, 0);
        chk("s_pre_rst_hsync", hs_s, 0);
        chk("s_pre_rst_vsync", vs_s, 0);

        reset_s = 1'b1;
        #1;
        chk("s_mid_rst_hsync", hs_s, 1);
        chk("s_mid_rst_vsync", vs_s, 1);
        chk("s_mid_rst_x", x_s, 0);
        chk("s_mid_rst_y", y_s, 0);
        @(negedge clk);
        @(negedge clk);
        reset_s = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            @(negedge clk);
            chk($sformatf("s_resume_ptick@%0d", k), pt_s, (k % 2 == 0));
            chk($sformatf("s_resume_x@%0d", k), x_s, (k + 1) / 2);
            chk($sformatf("s_resume_vsync@%0d", k), vs_s, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
